// File: rtl/irq_gather_if.sv
// irq_gather_if: signal bundle between the interrupt gather stage and the core.
//   master : the core/test side. It drives irq_in, the fault pulses, eoi,
//            the timer load strobe and value, and overrun_clr.
//   slave  : irq_gather. It drives timer_value, irq and irq_overrun.
// TIMER_W sets the width of the timer load value and the timer count.
interface irq_gather_if #(
    parameter int TIMER_W = 32
);
    logic [31:0]        irq_in;
    logic               ebreak_pulse;
    logic               buserror_pulse;
    logic [31:0]        eoi;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value_in;
    logic [TIMER_W-1:0] timer_value;
    logic [31:0]        irq;
    logic [31:0]        irq_overrun;
    logic [31:0]        overrun_clr;

    modport master (
        output irq_in, ebreak_pulse, buserror_pulse, eoi,
               timer_load, timer_value_in, overrun_clr,
        input  timer_value, irq, irq_overrun
    );

    modport slave (
        input  irq_in, ebreak_pulse, buserror_pulse, eoi,
               timer_load, timer_value_in, overrun_clr,
        output timer_value, irq, irq_overrun
    );
endinterface

// File: rtl/irq_gather.sv
// irq_gather: interrupt source stage in front of the core's IRQ unit.
// It synchronises the 32 external lines, detects edges or levels on them,
// merges in the core fault pulses and an optional down-count timer, and
// registers the irq vector that the core samples. Latched bits are cleared
// by eoi. An event that arrives while its bit is still pending and not being
// acknowledged sets a sticky overrun flag.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high; clears every flop
//   bus    irq_gather_if.slave
//          irq_in[31:0]     asynchronous external lines
//          ebreak_pulse     source bit 1; buserror_pulse  source bit 2
//          eoi[31:0]        acknowledge for latched bits
//          timer_load, timer_value_in, timer_value   (down-count timer)
//          irq[31:0]        registered vector to the core
//          irq_overrun, overrun_clr   sticky lost-event flags, write-1-to-clear
//
// Build option IRQ_GATHER_TIMER_EN:
//   defined   - the timer is built and its expiry drives bit 0
//   undefined - there is no timer; timer_value reads 0 and bit 0 comes
//               from irq_in[0] like bits 3..31
module irq_gather #(
    parameter logic [31:0] LATCHED_IRQ = 32'hffff_ffff,
    parameter logic [31:0] EDGE_IRQ    = 32'h0000_0000,
    parameter int          TIMER_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    irq_gather_if.slave bus
);

`ifdef IRQ_GATHER_TIMER_EN
    localparam logic [31:0] INT_MASK = 32'h0000_0007;
`else
    localparam logic [31:0] INT_MASK = 32'h0000_0006;
`endif
    // The internal sources are always latched, whatever LATCHED_IRQ says.
    localparam logic [31:0] LAT = LATCHED_IRQ | INT_MASK;

    logic [31:0] s1, s2, prev;
    logic [31:0] ev;
    logic [31:0] irq_q, ovr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= bus.irq_in;
            s2   <= s1;
            prev <= s2;
        end
    end

`ifdef IRQ_GATHER_TIMER_EN
    typedef enum logic {T_IDLE, T_RUN} tstate_t;
    tstate_t            tstate;
    logic [TIMER_W-1:0] tcnt;
    logic               tmr_ev;

    // Expiry is the 1->0 step. A load in the same cycle takes priority and
    // suppresses the event.
    assign tmr_ev = (tstate == T_RUN) && !bus.timer_load && (tcnt == TIMER_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tstate <= T_IDLE;
            tcnt   <= '0;
        end else if (bus.timer_load) begin
            tcnt   <= bus.timer_value_in;
            tstate <= (bus.timer_value_in != '0) ? T_RUN : T_IDLE;
        end else begin
            case (tstate)
                // RUN always holds a nonzero count, so this never wraps.
                T_RUN: begin
                    tcnt <= tcnt - TIMER_W'(1);
                    if (tcnt == TIMER_W'(1))
                        tstate <= T_IDLE;
                end
                default: tcnt <= '0;
            endcase
        end
    end

    assign bus.timer_value = tcnt;
`else
    logic unused_timer;
    assign unused_timer    = ^{bus.timer_load, bus.timer_value_in};
    assign bus.timer_value = '0;
`endif

    always_comb begin
        ev    = (EDGE_IRQ & s2 & ~prev) | (~EDGE_IRQ & s2);
        ev[1] = bus.ebreak_pulse;
        ev[2] = bus.buserror_pulse;
`ifdef IRQ_GATHER_TIMER_EN
        ev[0] = tmr_ev;
`endif
    end

    // A new event takes priority over eoi on latched bits. Level bits simply
    // follow the synchronised line and never record an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= '0;
            ovr_q <= '0;
        end else begin
            irq_q <= (LAT & ((irq_q & ~bus.eoi) | ev)) | (~LAT & s2);
            ovr_q <= (ovr_q & ~bus.overrun_clr) | (LAT & ev & irq_q & ~bus.eoi);
        end
    end

    assign bus.irq         = irq_q;
    assign bus.irq_overrun = ovr_q;

endmodule

// File: tb/tb_irq_gather.sv
module tb_irq_gather;
    localparam logic [31:0] LAT = 32'hffff_fdff;  // bit 9 is a level line
    localparam logic [31:0] EDG = 32'h0f00_0021;  // bits 0, 5 and 24..27 are edge lines
    localparam int          TW  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    irq_gather_if #(.TIMER_W(TW)) bus();

    irq_gather #(.LATCHED_IRQ(LAT), .EDGE_IRQ(EDG), .TIMER_W(TW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model. It keeps the irq_in value seen at each clock edge.
    // The pipeline sees a sample two edges old as the current line value,
    // and a sample three edges old as the previous one.
    logic [31:0] hist[$];
    logic [31:0] m_irq, m_ovr;
    int          m_tcnt;
    bit          model_on = 0;

    function automatic logic [31:0] seen(input int back);
        if (hist.size() > back) return hist[hist.size()-1-back];
        return 32'h0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_irq = 0; m_ovr = 0; m_tcnt = 0;
    endtask

    task automatic model_edge();
        logic [31:0] lvl, rise, ev, lm, nov;
        lvl  = seen(1);
        rise = lvl & ~seen(2);
        ev   = (EDG & rise) | (~EDG & lvl);
        ev[1] = bus.ebreak_pulse;
        ev[2] = bus.buserror_pulse;
`ifdef IRQ_GATHER_TIMER_EN
        lm = LAT | 32'h7;
        ev[0] = 1'b0;
        if (bus.timer_load) m_tcnt = int'(bus.timer_value_in);
        else if (m_tcnt > 0) begin
            m_tcnt = m_tcnt - 1;
            ev[0] = (m_tcnt == 0);
        end
`else
        lm = LAT | 32'h6;
`endif
        nov   = (m_ovr & ~bus.overrun_clr) | (ev & m_irq & ~bus.eoi & lm);
        m_irq = (lm & ((m_irq & ~bus.eoi) | ev)) | (~lm & lvl);
        m_ovr = nov;
        hist.push_back(bus.irq_in);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        if (model_on && !reset) model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.irq_in = 0; bus.ebreak_pulse = 0; bus.buserror_pulse = 0;
        bus.eoi = 0; bus.timer_load = 0; bus.timer_value_in = 0; bus.overrun_clr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        #1;
        check("rst_irq", bus.irq, 32'h0);
        check("rst_ovr", bus.irq_overrun, 32'h0);
        check("rst_tv", 32'(bus.timer_value), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic        eb, be;
        logic [31:0] eoi, oclr, exp_irq, exp_ovr;
    } vec_t;
    vec_t tbl[8];

    initial begin
        idle_inputs();
        tbl[0] = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h2, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h2, 32'h2};
        tbl[2] = '{1'b0, 1'b1, 32'h2, 32'h0, 32'h4, 32'h2};
        tbl[3] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h4, 32'h6};
        tbl[4] = '{1'b0, 1'b1, 32'h4, 32'h0, 32'h4, 32'h6};  // set beats eoi
        tbl[5] = '{1'b0, 1'b0, 32'h0, 32'h4, 32'h4, 32'h2};  // overrun clear
        tbl[6] = '{1'b0, 1'b1, 32'h0, 32'h4, 32'h4, 32'h6};  // set beats clear
        tbl[7] = '{1'b0, 1'b0, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 32'h0};

        do_reset();
        repeat (3) step();
        check("idle_irq", bus.irq, 32'h0);
        check("idle_ovr", bus.irq_overrun, 32'h0);

        // Internal pulse sources, set/clear collisions
        for (int i = 0; i < 8; i++) begin
            bus.ebreak_pulse = tbl[i].eb; bus.buserror_pulse = tbl[i].be;
            bus.eoi = tbl[i].eoi; bus.overrun_clr = tbl[i].oclr;
            step();
            check($sformatf("tbl%0d_irq", i), bus.irq, tbl[i].exp_irq);
            check($sformatf("tbl%0d_ovr", i), bus.irq_overrun, tbl[i].exp_ovr);
        end
        idle_inputs();

        // Edge latch on bit 5
        do_reset();
        bus.irq_in[5] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("edge5_c%0d", k), bus.irq, (k >= 3) ? 32'h20 : 32'h0);
        end
        bus.eoi[5] = 1'b1;
        step();
        bus.eoi[5] = 1'b0;
        check("edge5_eoi", bus.irq, 32'h0);
        repeat (3) step();
        check("edge5_noretrig", bus.irq, 32'h0);
        check("edge5_ovr", bus.irq_overrun, 32'h0);
        idle_inputs();

        // Level pass-through on bit 9, eoi held high throughout
        do_reset();
        bus.eoi[9] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus.irq_in[9] = (k <= 4);
            step();
            check($sformatf("lvl9_c%0d", k), bus.irq, (k >= 3 && k <= 6) ? 32'h200 : 32'h0);
        end
        idle_inputs();

`ifdef IRQ_GATHER_TIMER_EN
        do_reset();
        bus.timer_load = 1'b1; bus.timer_value_in = 16'd5;
        step();
        bus.timer_load = 1'b0;
        check("tmr_load", 32'(bus.timer_value), 32'd5);
        for (int k = 4; k >= 0; k--) begin
            step();
            check($sformatf("tmr_cnt%0d", k), 32'(bus.timer_value), 32'(k));
            check($sformatf("tmr_irq%0d", k), bus.irq, (k == 0) ? 32'h1 : 32'h0);
        end
        step();
        check("tmr_nowrap", 32'(bus.timer_value), 32'd0);
        bus.eoi[0] = 1'b1;
        bus.timer_load = 1'b1; bus.timer_value_in = 16'd2;
        step();
        bus.eoi[0] = 1'b0; bus.timer_load = 1'b0;
        step();
        check("tmr_at1", 32'(bus.timer_value), 32'd1);
        bus.timer_load = 1'b1; bus.timer_value_in = 16'd3;
        step();
        check("tmr_reload_cnt", 32'(bus.timer_value), 32'd3);
        check("tmr_reload_noirq", bus.irq, 32'h0);
        bus.timer_value_in = 16'd0;
        step();
        bus.timer_load = 1'b0;
        step();
        check("tmr_load0_cnt", 32'(bus.timer_value), 32'd0);
        check("tmr_load0_noirq", bus.irq, 32'h0);
        idle_inputs();
`else
        // Bit 0 from irq_in[0]; the timer inputs are ignored
        do_reset();
        bus.irq_in[0] = 1'b1;
        bus.timer_load = 1'b1; bus.timer_value_in = 16'd7;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("bit0_c%0d", k), bus.irq, (k >= 3) ? 32'h1 : 32'h0);
            check($sformatf("tv0_c%0d", k), 32'(bus.timer_value), 32'h0);
        end
        idle_inputs();
`endif

        // Reset while the design is busy
        do_reset();
        bus.irq_in = 32'h0000_0108;
        bus.timer_load = 1'b1; bus.timer_value_in = 16'd9;
        step();
        bus.timer_load = 1'b0;
        step(); step();
        check("pre_rst_irq", bus.irq, 32'h108);
        step();
        check("pre_rst_ovr", bus.irq_overrun, 32'h108);
        do_reset();
        repeat (4) step();
        check("post_rst_irq", bus.irq, 32'h0);
        check("post_rst_ovr", bus.irq_overrun, 32'h0);
        check("post_rst_tv", 32'(bus.timer_value), 32'h0);

        // Randomised run against the reference model
        do_reset();
        model_on = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            bus.irq_in         = bus.irq_in ^ ($urandom & $urandom & $urandom);
            bus.ebreak_pulse   = ($urandom % 4) == 0;
            bus.buserror_pulse = ($urandom % 5) == 0;
            bus.eoi            = $urandom & $urandom;
            bus.overrun_clr    = $urandom & $urandom & $urandom;
            bus.timer_load     = ($urandom % 16) == 0;
            bus.timer_value_in = 16'($urandom % 12);
            step();
            check("rnd_irq", bus.irq, m_irq);
            check("rnd_ovr", bus.irq_overrun, m_ovr);
`ifdef IRQ_GATHER_TIMER_EN
            check("rnd_tv", 32'(bus.timer_value), 32'(m_tcnt));
`else
            check("rnd_tv", 32'(bus.timer_value), 32'h0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_gather.md
Name: irq_gather

Overview:
- Interrupt source stage directly upstream of the core's IRQ unit.
- Synchronises 32 external interrupt lines and detects edges on them.
- Merges in an internal down-count timer and core fault pulses.
- Produces the registered `irq[31:0]` vector the core samples; clears latched bits from the core's `eoi[31:0]` and records lost (overrun) events.

Parameters:
- LATCHED_IRQ, 32'hffff_ffff, bit=1: line is latched until acknowledged by eoi; bit=0: level pass-through.
- EDGE_IRQ, 32'h0000_0000, bit=1: latched line triggers on rising edge; bit=0: triggers on any high sample. Ignored where LATCHED_IRQ bit=0.
- TIMER_W, 32, timer counter width (1..32).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- irq_in  input  32  external interrupt lines, asynchronous to clk
- ebreak_pulse  input  1  one-cycle EBREAK/ECALL event from core, source bit 1
- buserror_pulse  input  1  one-cycle bus-error event from core, source bit 2
- eoi  input  32  end-of-interrupt acknowledge bits from core
- timer_load  input  1  load strobe for timer
- timer_value_in  input  TIMER_W  timer load value; 0 disables timer
- timer_value  output  TIMER_W  current timer count
- irq  output  32  registered interrupt vector to core
- irq_overrun  output  32  sticky lost-event flags
- overrun_clr  input  32  write-1-to-clear for irq_overrun

Behaviour:
- Reset is asynchronous and active-high. While asserted, all flops are 0: sync stages, edge history, irq, irq_overrun, timer_value.
- Synchroniser:
  - 2 flops per line: s1 <= irq_in; s2 <= s1.
  - Edge history: prev <= s2.
  - Lines 0, 1 and 2 of irq_in are also synchronised but are ignored by default; see per-bit sources below.
- Event per bit i:
  - EDGE_IRQ[i]=1: ev = s2 & ~prev.
  - EDGE_IRQ[i]=0: ev = s2.
  - Bit 0 = timer expiry; bit 1 = ebreak_pulse; bit 2 = buserror_pulse. These three are always latched and are unaffected by LATCHED_IRQ/EDGE_IRQ.
- Latched bits: irq[i] <= (irq[i] & ~eoi[i]) | ev[i].
  - Set wins over eoi in the same cycle; the new event is never lost.
- Level bits: irq[i] <= s2[i]. eoi has no effect.
- Latency: an irq_in change is visible on irq exactly 3 clk edges later; internal pulses are visible 1 edge later.
- Overrun (latched bits only):
  - irq_overrun[i] <= (irq_overrun[i] & ~overrun_clr[i]) | (ev[i] & irq[i] & ~eoi[i]).
  - Set wins over clear.
  - For EDGE_IRQ=0 lines, a held level re-triggers every cycle; overrun therefore sets on the 2nd cycle if unacknowledged. This is intended.
- Timer state machine (IDLE, RUN):
  - IDLE: timer_value=0. timer_load with nonzero value → RUN, count = value.
  - RUN: count decrements by 1 per cycle. The transition 1→0 raises ev[0] for one cycle and returns to IDLE.
  - timer_load in either state reloads the count. Load of 0 → IDLE with no event.
  - Load coincident with the 1→0 step: load wins and no event is raised.
  - No wrap-around: the counter never decrements below 0.
- Reset mid-operation: all pending, overrun and timer state is discarded. irq drops to 0 asynchronously.

Optional Feature:
- Macro IRQ_GATHER_TIMER_EN.
- Defined: timer as specified; bit 0 = timer expiry.
- Undefined:
  - No timer logic.
  - timer_value ties to 0; timer_load and timer_value_in are ignored.
  - Bit 0 is sourced from irq_in[0] under the LATCHED_IRQ/EDGE_IRQ rules like bits 3..31.

Test Plan:
- Reset: assert reset mid-count with irq=32'h0000_0108 → irq, irq_overrun and timer_value read 0 immediately; after release all stay 0 with idle inputs.
- Edge latch: EDGE_IRQ bit 5=1, irq_in[5] 0→1 at cycle 0 and held → irq[5]=1 from cycle 3 and stays 1; eoi[5] pulse at cycle 10 → irq[5]=0 at cycle 11 with no re-trigger.
- Level pass-through: LATCHED_IRQ bit 9=0, irq_in[9] high for 4 cycles → irq[9] high for exactly 4 cycles, delayed by 3; eoi[9] has no effect.
- Timer: load 5 → timer_value 5,4,3,2,1,0; irq[0]=1 on the edge the count reaches 0; reload 3 on the cycle count would hit 0 → no irq[0], count=3.
- Set/clear collision: buserror_pulse and eoi[2] in the same cycle while irq[2]=1 → irq[2] stays 1 and irq_overrun[2]=1; overrun_clr[2] next cycle → irq_overrun[2]=0.
- Macro off: build without IRQ_GATHER_TIMER_EN, rising edge on irq_in[0] with EDGE_IRQ bit 0=1 → irq[0]=1 after 3 cycles; timer_value constant 0.
